sumador_serie: RTL and testbench



---
 rtl/sumador_serie.sv | 144 ++++++++++++++
 tb/tb_sumador_serie.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sumador_serie.sv
// Bit-serial adder: one full-adder cell processes one bit pair per clock, LSB first.

// Single-bit full-adder cell driven by the serial sequencer.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    // Plain combinational full-adder equations.
    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// Sequencer that feeds the cell, stores the carry and assembles the WIDTH-bit result.
module sumador_serie #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] OP_A,
    input  logic [WIDTH-1:0] OP_B,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             COUT
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_a_q, sh_a_d;
    logic [WIDTH-1:0]   sh_b_q, sh_b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               fa_sum;
    logic               fa_cout;

    // The single adder cell always sees the current LSBs and the stored carry.
    full_adder u_fa (
        .a         (sh_a_q[0]),
        .b         (sh_b_q[0]),
        .carry_in  (carry_q),
        .sum       (fa_sum),
        .carry_out (fa_cout)
    );

    // Next-state and datapath logic; FIN accepts START exactly like IDLE for back-to-back use.
    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE, S_FIN: begin
                if (START) begin
                    sh_a_d  = OP_A;
                    sh_b_d  = OP_B;
                    carry_d = CIN;
                    cnt_d   = '0;
                    res_d   = '0;
                    cout_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                carry_d = fa_cout;
                sh_a_d  = {1'b0, sh_a_q[WIDTH-1:1]};
                sh_b_d  = {1'b0, sh_b_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Final bit: latch carry-out, pulse DONE, park the counter.
                    cnt_d   = '0;
                    cout_d  = fa_cout;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FIN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = res_q;
    assign COUT   = cout_q;

endmodule

// File: tb/tb_sumador_serie.sv
// Directed and random checks of the bit-serial adder at WIDTH=8 and WIDTH=3.
module tb_sumador_serie;

    logic       clk;
    logic       rst_n;

    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       cout;

    logic       start3;
    logic [2:0] op_a3;
    logic [2:0] op_b3;
    logic       cin3;
    logic       busy3;
    logic       done3;
    logic [2:0] result3;
    logic       cout3;

    int pass_cnt  = 0;
    int check_cnt = 0;

    sumador_serie #(.WIDTH(8)) u_dut8 (
        .CLK    (clk),
        .RST_N  (rst_n),
        .START  (start),
        .OP_A   (op_a),
        .OP_B   (op_b),
        .CIN    (cin),
        .BUSY   (busy),
        .DONE   (done),
        .RESULT (result),
        .COUT   (cout)
    );

    sumador_serie #(.WIDTH(3)) u_dut3 (
        .CLK    (clk),
        .RST_N  (rst_n),
        .START  (start3),
        .OP_A   (op_a3),
        .OP_B   (op_b3),
        .CIN    (cin3),
        .BUSY   (busy3),
        .DONE   (done3),
        .RESULT (result3),
        .COUT   (cout3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0; op_a  = '0; op_b  = '0; cin  = 1'b0;
        start3 = 1'b0; op_a3 = '0; op_b3 = '0; cin3 = 1'b0;
        tick();
        tick();
        check_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        check_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
        check_cnt++;
        if (result !== 8'h00) $display("FAIL reset_result got=%h exp=00", result); else pass_cnt++;
        check_cnt++;
        if (cout !== 1'b0) $display("FAIL reset_cout got=%b exp=0", cout); else pass_cnt++;
        check_cnt++;
        if ({busy3, done3, cout3, result3} !== 6'b0) $display("FAIL reset_w3 got=%b exp=000000", {busy3, done3, cout3, result3}); else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    // Cycle-exact timing of the first operation: BUSY after k..k+7, DONE only after k+8.
    task automatic test_basic_timing();
        start = 1'b1; op_a = 8'h5A; op_b = 8'h33; cin = 1'b0;
        tick();
        start = 1'b0; op_a = 8'hFF; op_b = 8'hFF; cin = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_cnt++;
            if (busy !== 1'b1 || done !== 1'b0)
                $display("FAIL run_cycle%0d busy=%b done=%b exp busy=1 done=0", i, busy, done);
            else pass_cnt++;
            tick();
        end
        check_cnt++;
        if (done !== 1'b1 || busy !== 1'b0) $display("FAIL basic_done done=%b busy=%b exp done=1 busy=0", done, busy); else pass_cnt++;
        check_cnt++;
        if (result !== 8'h8D) $display("FAIL basic_result got=%h exp=8d", result); else pass_cnt++;
        check_cnt++;
        if (cout !== 1'b0) $display("FAIL basic_cout got=%b exp=0", cout); else pass_cnt++;
        tick();
        check_cnt++;
        if (done !== 1'b0) $display("FAIL basic_done_drop got=%b exp=0", done); else pass_cnt++;
        check_cnt++;
        if (result !== 8'h8D || cout !== 1'b0) $display("FAIL basic_hold got=%b_%h exp=0_8d", cout, result); else pass_cnt++;
    endtask

    // One full operation on the 8-bit DUT with latency and result checks.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] exp_res, input logic exp_cout, input string name);
        int n;
        start = 1'b1; op_a = a; op_b = b; cin = c;
        tick();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_cnt++;
        if (n !== 8) $display("FAIL %s_latency got=%0d exp=8", name, n); else pass_cnt++;
        check_cnt++;
        if (result !== exp_res) $display("FAIL %s_result got=%h exp=%h", name, result, exp_res); else pass_cnt++;
        check_cnt++;
        if (cout !== exp_cout) $display("FAIL %s_cout got=%b exp=%b", name, cout, exp_cout); else pass_cnt++;
        tick();
    endtask

    task automatic test_carry_cases();
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_plus_01");
        run_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "ff_plus_cin");
        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
        run_op(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, "alt_cin");
    endtask

    // START during RUN must neither resample operands nor shift DONE timing.
    task automatic test_start_ignored();
        int n;
        start = 1'b1; op_a = 8'h5A; op_b = 8'h33; cin = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        start = 1'b1; op_a = 8'h01; op_b = 8'h01; cin = 1'b1;
        tick();
        start = 1'b0;
        n = 4;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_cnt++;
        if (n !== 8) $display("FAIL ignore_latency got=%0d exp=8", n); else pass_cnt++;
        check_cnt++;
        if (result !== 8'h8D || cout !== 1'b0) $display("FAIL ignore_result got=%b_%h exp=0_8d", cout, result); else pass_cnt++;
        tick();
        check_cnt++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL ignore_idle busy=%b done=%b exp 0 0", busy, done); else pass_cnt++;
    endtask

    // Synchronous reset at edge k+4 aborts the operation with no DONE.
    task automatic test_reset_mid_op();
        int seen;
        start = 1'b1; op_a = 8'hF0; op_b = 8'h0F; cin = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        check_cnt++;
        if (busy !== 1'b0 || result !== 8'h00 || cout !== 1'b0 || done !== 1'b0)
            $display("FAIL midreset_state busy=%b done=%b res=%h cout=%b exp 0 0 00 0", busy, done, result, cout);
        else pass_cnt++;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            tick();
        end
        check_cnt++;
        if (seen !== 0) $display("FAIL midreset_no_done got=%0d active cycles exp=0", seen); else pass_cnt++;
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "after_reset");
    endtask

    // START held high: accepts at FIN, DONE every 9 cycles.
    task automatic test_back_to_back();
        int n;
        start = 1'b1; op_a = 8'h10; op_b = 8'h20; cin = 1'b0;
        tick();
        op_a = 8'h80; op_b = 8'h80; cin = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_cnt++;
        if (n !== 8) $display("FAIL b2b_first_latency got=%0d exp=8", n); else pass_cnt++;
        check_cnt++;
        if (result !== 8'h30 || cout !== 1'b0) $display("FAIL b2b_first got=%b_%h exp=0_30", cout, result); else pass_cnt++;
        n = 0;
        tick();
        n++;
        check_cnt++;
        if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_reaccept busy=%b done=%b exp 1 0", busy, done); else pass_cnt++;
        op_a = 8'h01; op_b = 8'h02; cin = 1'b0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_cnt++;
        if (n !== 9) $display("FAIL b2b_period got=%0d exp=9", n); else pass_cnt++;
        check_cnt++;
        if (result !== 8'h00 || cout !== 1'b1) $display("FAIL b2b_second got=%b_%h exp=1_00", cout, result); else pass_cnt++;
        start = 1'b0;
        tick();
        check_cnt++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_stop busy=%b done=%b exp 0 0", busy, done); else pass_cnt++;
    endtask

    // Random operands on both widths against an arithmetic reference.
    task automatic test_random();
        logic [8:0] exp9;
        logic [3:0] exp4;
        int         n;
        for (int i = 0; i < 1000; i++) begin
            op_a = 8'($urandom_range(0, 255));
            op_b = 8'($urandom_range(0, 255));
            cin  = 1'($urandom_range(0, 1));
            exp9 = 9'(op_a) + 9'(op_b) + 9'(cin);
            start = 1'b1;
            tick();
            start = 1'b0;
            n = 0;
            while (done !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            check_cnt++;
            if (n !== 8 || {cout, result} !== exp9)
                $display("FAIL rand8_%0d got=%h lat=%0d exp=%h lat=8", i, {cout, result}, n, exp9);
            else pass_cnt++;
            tick();
            check_cnt++;
            if (done !== 1'b0) $display("FAIL rand8_pulse_%0d done=%b exp=0", i, done); else pass_cnt++;
        end
        for (int i = 0; i < 1000; i++) begin
            op_a3 = 3'($urandom_range(0, 7));
            op_b3 = 3'($urandom_range(0, 7));
            cin3  = 1'($urandom_range(0, 1));
            exp4  = 4'(op_a3) + 4'(op_b3) + 4'(cin3);
            start3 = 1'b1;
            tick();
            start3 = 1'b0;
            n = 0;
            while (done3 !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            check_cnt++;
            if (n !== 3 || {cout3, result3} !== exp4)
                $display("FAIL rand3_%0d got=%h lat=%0d exp=%h lat=3", i, {cout3, result3}, n, exp4);
            else pass_cnt++;
            tick();
            check_cnt++;
            if (done3 !== 1'b0) $display("FAIL rand3_pulse_%0d done=%b exp=0", i, done3); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_timing();
        test_carry_cases();
        test_start_ignored();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
